// File: rtl/axis_uart_pkg.sv
// Shared definitions for the UART transmit-path source arbiter.
//   arb_state_e : arbiter FSM states
//   HDR_TAG     : upper nibble of the per-packet source-tag header byte
//   TERM_BYTE   : byte that closes a frame aborted by idle timeout
//   BAUD_DIV    : system clocks per UART bit
package axis_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ABORT
  } arb_state_e;

  localparam logic [3:0]  HDR_TAG   = 4'hA;
  localparam logic [7:0]  TERM_BYTE = 8'h00;
  localparam int unsigned BAUD_DIV  = 434;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder. The first requester strictly after ptr_i
// (wrapping through N-1 back to 0) wins.
//   req_i : request vector
//   ptr_i : index of the most recent winner
//   gnt_o : one-hot winner, zero when nothing requests
//   idx_o : binary index of the winner
//   any_o : at least one request present
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [3:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [3:0]   idx_o,
  output logic         any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // Pass one covers indices above the pointer, pass two wraps to the rest.
    for (int unsigned j = 0; j < N; j++) begin
      if (!any_o && req_i[j] && (j > int'(ptr_i))) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = 4'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!any_o && req_i[j] && (j <= int'(ptr_i))) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = 4'(j);
      end
    end
  end

endmodule

// File: rtl/axis_uart_arb.sv
// Packet-granular round-robin arbiter feeding the UART TX FIFO.
// Each packet is prefixed with a {HDR_TAG, src} header byte; a stalled owner
// is released after TIMEOUT_CYC idle cycles and its frame closed with TERM_BYTE.
//   clk, rst            : clock, asynchronous active-low reset
//   s_axis_*            : N_SRC byte-stream sources (source i at data[8i+7:8i])
//   axis_*/m_axis_ready : registered master stream toward the UART FIFO
//   grant               : one-hot current owner, zero when idle
//   abort/abort_src     : one-cycle pulse and source index on timeout close
module axis_uart_arb
  import axis_uart_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned TIMEOUT_CYC = 10 * BAUD_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] s_axis_data,
  input  logic [N_SRC-1:0]   s_axis_valid,
  input  logic [N_SRC-1:0]   s_axis_last,
  output logic [N_SRC-1:0]   s_axis_ready,
  output logic [7:0]         axis_data,
  output logic               axis_valid,
  output logic               axis_last,
  input  logic               m_axis_ready,
  output logic [N_SRC-1:0]   grant,
  output logic               abort,
  output logic [3:0]         abort_src
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e         state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [3:0]         gidx_q, gidx_d;
  logic [3:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               abort_q, abort_d;
  logic [3:0]         abort_src_q, abort_src_d;

  logic [N_SRC-1:0]   pick_gnt;
  logic [3:0]         pick_idx;
  logic               pick_any;
  logic               free;
  logic               cur_valid;
  logic               cur_last;
  logic [7:0]         cur_data;
  logic               timed_out;

  rr_pick #(.N(N_SRC)) u_pick (
    .req_i (s_axis_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign free      = !valid_q || m_axis_ready;
  assign cur_valid = |(s_axis_valid & grant_q);
  assign cur_last  = |(s_axis_last & grant_q);
  assign timed_out = (cnt_q == CW'(TIMEOUT_CYC));

  always_comb begin
    cur_data = '0;
    for (int unsigned j = 0; j < N_SRC; j++) begin
      if (gidx_q == 4'(j)) cur_data = s_axis_data[8*j +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    last_d       = last_q;
    abort_d      = 1'b0;
    abort_src_d  = abort_src_q;
    s_axis_ready = '0;
    // A free out-reg drains unless one of the branches below reloads it.
    valid_d      = free ? 1'b0 : valid_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any && free) begin
          state_d = DATA;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          data_d  = {HDR_TAG, pick_idx};
          last_d  = 1'b0;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      DATA: begin
        // Timeout wins over a beat arriving on the same cycle: ready stays low.
        if (timed_out) begin
          state_d = ABORT;
          grant_d = '0;
        end else begin
          s_axis_ready = grant_q & {N_SRC{free}};
          if (cur_valid) begin
            // Valid but stalled is backpressure; the counter holds.
            if (free) begin
              data_d  = cur_data;
              last_d  = cur_last;
              valid_d = 1'b1;
              cnt_d   = '0;
              if (cur_last) begin
                rr_ptr_d = gidx_q;
                grant_d  = '0;
                state_d  = IDLE;
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ABORT: begin
        if (free) begin
          data_d      = TERM_BYTE;
          last_d      = 1'b1;
          valid_d     = 1'b1;
          abort_d     = 1'b1;
          abort_src_d = gidx_q;
          rr_ptr_d    = gidx_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= 4'(N_SRC - 1);
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      abort_q     <= 1'b0;
      abort_src_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      abort_q     <= abort_d;
      abort_src_q <= abort_src_d;
    end
  end

  assign axis_data  = data_q;
  assign axis_valid = valid_q;
  assign axis_last  = last_q;
  assign grant      = grant_q;
  assign abort      = abort_q;
  assign abort_src  = abort_src_q;

endmodule

// File: tb/tb_axis_uart_arb.sv
module tb_axis_uart_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 4340;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  s_data  = '0;
  logic [3:0]   s_valid = '0;
  logic [3:0]   s_last  = '0;
  logic [3:0]   s_ready;
  logic [7:0]   axis_data;
  logic         axis_valid;
  logic         axis_last;
  logic         m_ready = 1'b1;
  logic [3:0]   grant;
  logic         abort;
  logic [3:0]   abort_src;
  logic [13:0]  obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_uart_arb #(.N_SRC(N), .TIMEOUT_CYC(TO)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_last  (s_last),
    .s_axis_ready (s_ready),
    .axis_data    (axis_data),
    .axis_valid   (axis_valid),
    .axis_last    (axis_last),
    .m_axis_ready (m_ready),
    .grant        (grant),
    .abort        (abort),
    .abort_src    (abort_src)
  );

  // {grant, valid, last, data}
  assign obs = {grant, axis_valid, axis_last, axis_data};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic l);
    s_valid[i]       = v;
    s_data[8*i +: 8] = d;
    s_last[i]        = l;
  endtask

  task automatic test_reset;
    tick;
    n_cmp++;
    if (obs !== 14'h0) begin
      n_bad++; $display("FAIL reset_out: got %h want %h", obs, 14'h0);
    end
    n_cmp++;
    if ({s_ready, abort, abort_src} !== 9'h0) begin
      n_bad++; $display("FAIL reset_ctl: got %h want %h", {s_ready, abort, abort_src}, 9'h0);
    end
    rst = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [13:0] exp;
    logic [3:0]  oh;
    for (int i = 0; i < 4; i++) set_src(i, 1'b1, 8'(8'hB0 + i), 1'b1);
    for (int r = 0; r < 5; r++) begin
      oh = 4'(1 << (r % 4));
      tick;
      exp = {oh, 1'b1, 1'b0, 4'hA, 4'(r % 4)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL rr_hdr%0d: got %h want %h", r, obs, exp);
      end
      n_cmp++;
      if (s_ready !== oh) begin
        n_bad++; $display("FAIL rr_ready%0d: got %b want %b", r, s_ready, oh);
      end
      tick;
      exp = {4'h0, 1'b1, 1'b1, 8'(8'hB0 + (r % 4))};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL rr_byte%0d: got %h want %h", r, obs, exp);
      end
    end
    s_valid = '0;
    tick;
    n_cmp++;
    if ({grant, axis_valid} !== 5'h0) begin
      n_bad++; $display("FAIL rr_drain: got %h want %h", {grant, axis_valid}, 5'h0);
    end
  endtask

  task automatic test_single;
    set_src(0, 1'b1, 8'h11, 1'b0);
    tick;
    n_cmp++;
    if (obs !== {4'b0001, 1'b1, 1'b0, 8'hA0}) begin
      n_bad++; $display("FAIL single_hdr: got %h want %h", obs, {4'b0001, 1'b1, 1'b0, 8'hA0});
    end
    n_cmp++;
    if (s_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single_ready: got %b want %b", s_ready, 4'b0001);
    end
    tick;
    n_cmp++;
    if (obs !== {4'b0001, 1'b1, 1'b0, 8'h11}) begin
      n_bad++; $display("FAIL single_b0: got %h want %h", obs, {4'b0001, 1'b1, 1'b0, 8'h11});
    end
    set_src(0, 1'b1, 8'h22, 1'b0);
    tick;
    n_cmp++;
    if (obs !== {4'b0001, 1'b1, 1'b0, 8'h22}) begin
      n_bad++; $display("FAIL single_b1: got %h want %h", obs, {4'b0001, 1'b1, 1'b0, 8'h22});
    end
    set_src(0, 1'b1, 8'h33, 1'b1);
    tick;
    n_cmp++;
    if (obs !== {4'b0000, 1'b1, 1'b1, 8'h33}) begin
      n_bad++; $display("FAIL single_b2: got %h want %h", obs, {4'b0000, 1'b1, 1'b1, 8'h33});
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    tick;
    n_cmp++;
    if ({grant, axis_valid} !== 5'h0) begin
      n_bad++; $display("FAIL single_drain: got %h want %h", {grant, axis_valid}, 5'h0);
    end
  endtask

  task automatic test_backpressure;
    set_src(1, 1'b1, 8'h61, 1'b0);
    tick;
    n_cmp++;
    if (obs !== {4'b0010, 1'b1, 1'b0, 8'hA1}) begin
      n_bad++; $display("FAIL bp_hdr: got %h want %h", obs, {4'b0010, 1'b1, 1'b0, 8'hA1});
    end
    tick;
    set_src(1, 1'b1, 8'h62, 1'b1);
    m_ready = 1'b0;
    #1;
    n_cmp++;
    if (s_ready !== 4'b0000) begin
      n_bad++; $display("FAIL bp_ready_low: got %b want %b", s_ready, 4'b0000);
    end
    for (int k = 0; k < 20; k++) begin
      tick;
      n_cmp++;
      if ({obs, s_ready, abort} !== {4'b0010, 1'b1, 1'b0, 8'h61, 4'b0000, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got %h want %h", k, {obs, s_ready, abort},
                 {4'b0010, 1'b1, 1'b0, 8'h61, 4'b0000, 1'b0});
      end
    end
    m_ready = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 4'b0010) begin
      n_bad++; $display("FAIL bp_ready_resume: got %b want %b", s_ready, 4'b0010);
    end
    tick;
    n_cmp++;
    if (obs !== {4'b0000, 1'b1, 1'b1, 8'h62}) begin
      n_bad++; $display("FAIL bp_last: got %h want %h", obs, {4'b0000, 1'b1, 1'b1, 8'h62});
    end
    set_src(1, 1'b0, 8'h00, 1'b0);
    tick;
  endtask

  task automatic test_timeout;
    set_src(2, 1'b1, 8'h55, 1'b0);
    set_src(3, 1'b1, 8'h77, 1'b1);
    tick;
    n_cmp++;
    if (obs !== {4'b0100, 1'b1, 1'b0, 8'hA2}) begin
      n_bad++; $display("FAIL to_hdr: got %h want %h", obs, {4'b0100, 1'b1, 1'b0, 8'hA2});
    end
    tick;
    n_cmp++;
    if (obs !== {4'b0100, 1'b1, 1'b0, 8'h55}) begin
      n_bad++; $display("FAIL to_byte: got %h want %h", obs, {4'b0100, 1'b1, 1'b0, 8'h55});
    end
    set_src(2, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= int'(TO); k++) begin
      tick;
      if (k == 1) begin
        n_cmp++;
        if (obs !== {4'b0100, 1'b0, 1'b0, 8'h55}) begin
          n_bad++; $display("FAIL to_drain: got %h want %h", obs, {4'b0100, 1'b0, 1'b0, 8'h55});
        end
      end
      if (k == int'(TO)) begin
        n_cmp++;
        if ({grant, abort} !== {4'b0100, 1'b0}) begin
          n_bad++; $display("FAIL to_not_early: got %h want %h", {grant, abort}, {4'b0100, 1'b0});
        end
        set_src(2, 1'b1, 8'h99, 1'b0);
        #1;
        n_cmp++;
        if (s_ready !== 4'b0000) begin
          n_bad++; $display("FAIL to_fire_ready: got %b want %b", s_ready, 4'b0000);
        end
      end
    end
    tick;
    n_cmp++;
    if ({grant, axis_valid, abort} !== 6'h0) begin
      n_bad++; $display("FAIL to_fire: got %h want %h", {grant, axis_valid, abort}, 6'h0);
    end
    set_src(2, 1'b0, 8'h00, 1'b0);
    tick;
    n_cmp++;
    if ({obs, abort, abort_src} !== {4'b0000, 1'b1, 1'b1, 8'h00, 1'b1, 4'd2}) begin
      n_bad++;
      $display("FAIL to_term: got %h want %h", {obs, abort, abort_src},
               {4'b0000, 1'b1, 1'b1, 8'h00, 1'b1, 4'd2});
    end
    tick;
    n_cmp++;
    if ({obs, abort} !== {4'b1000, 1'b1, 1'b0, 8'hA3, 1'b0}) begin
      n_bad++;
      $display("FAIL to_next: got %h want %h", {obs, abort}, {4'b1000, 1'b1, 1'b0, 8'hA3, 1'b0});
    end
    tick;
    n_cmp++;
    if (obs !== {4'b0000, 1'b1, 1'b1, 8'h77}) begin
      n_bad++; $display("FAIL to_src3: got %h want %h", obs, {4'b0000, 1'b1, 1'b1, 8'h77});
    end
    set_src(3, 1'b0, 8'h00, 1'b0);
    tick;
  endtask

  task automatic test_async_reset;
    // Complete a src0 packet so the pointer sits at 0 before the reset.
    set_src(0, 1'b1, 8'hC0, 1'b1);
    tick;
    tick;
    set_src(0, 1'b0, 8'h00, 1'b0);
    set_src(1, 1'b1, 8'h12, 1'b0);
    tick;
    n_cmp++;
    if (obs !== {4'b0010, 1'b1, 1'b0, 8'hA1}) begin
      n_bad++; $display("FAIL ar_hdr: got %h want %h", obs, {4'b0010, 1'b1, 1'b0, 8'hA1});
    end
    tick;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({obs, s_ready, abort} !== 19'h0) begin
      n_bad++; $display("FAIL ar_clear: got %h want %h", {obs, s_ready, abort}, 19'h0);
    end
    tick;
    tick;
    n_cmp++;
    if ({obs, abort} !== 15'h0) begin
      n_bad++; $display("FAIL ar_no_term: got %h want %h", {obs, abort}, 15'h0);
    end
    set_src(0, 1'b1, 8'hE0, 1'b1);
    rst = 1'b1;
    tick;
    n_cmp++;
    if (obs !== {4'b0001, 1'b1, 1'b0, 8'hA0}) begin
      n_bad++; $display("FAIL ar_first: got %h want %h", obs, {4'b0001, 1'b1, 1'b0, 8'hA0});
    end
    s_valid = '0;
    tick;
    tick;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_backpressure;
    test_timeout;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
